// File: rtl/sba_dbg_bridge_pkg.sv
// Shared constants and state type for the serial-to-SBA debug bridge.
// Command/reply byte codes and the bridge FSM state enum.
package sba_dbg_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_e;

endpackage

// File: rtl/sba_dbg_bridge_if.sv
// Signal bundle of the debug bridge: UART rx/tx bytes, SBA bus, status.
// master = bridge side, slave = UART/SBA/status environment side.
interface sba_dbg_if;

  logic [7:0]  i_rx_dat;
  logic        i_rx_valid;
  logic [7:0]  o_tx_dat;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_addr;
  logic [31:0] o_dat_w;
  logic [3:0]  o_we;
  logic        o_stb;
  logic [31:0] i_dat_r;
  logic        i_ack;
  logic        o_busy;
  logic        o_overrun;

  modport master (
    input  i_rx_dat, i_rx_valid, i_tx_ready,
    input  i_dat_r, i_ack,
    output o_tx_dat, o_tx_valid,
    output o_addr, o_dat_w, o_we, o_stb,
    output o_busy, o_overrun
  );

  modport slave (
    output i_rx_dat, i_rx_valid, i_tx_ready,
    output i_dat_r, i_ack,
    input  o_tx_dat, o_tx_valid,
    input  o_addr, o_dat_w, o_we, o_stb,
    input  o_busy, o_overrun
  );

endinterface

// File: rtl/sba_dbg_bridge_txser.sv
// Reply serialiser: loads a word plus count (1 or 4), sends LSB first.
// Ports: i_load/i_word/i_four load; o_dat/o_valid/i_ready tx; o_last.
module sba_dbg_txser (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_four,
  input  logic        i_ready,
  output logic [7:0]  o_dat,
  output logic        o_valid,
  output logic        o_last
);

  logic [31:0] sh_q;
  logic [2:0]  left_q;

  assign o_valid = (left_q != 3'd0);
  assign o_dat   = sh_q[7:0];
  assign o_last  = o_valid && i_ready &&
                   (left_q == 3'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_q   <= '0;
      left_q <= '0;
    end else if (i_load) begin
      sh_q   <= i_word;
      left_q <= i_four ? 3'd4 : 3'd1;
    end else if (o_valid && i_ready) begin
      sh_q   <= sh_q >> 8;
      left_q <= left_q - 3'd1;
    end
  end

endmodule

// File: rtl/sba_dbg_bridge.sv
// Serial-to-SBA debug initiator: byte commands in, bus access, reply out.
// Ports: i_clk, i_rst (sync, high), bus (sba_dbg_if.master). SBA_DBG_TIMEOUT_EN.
module sba_dbg_bridge
  import sba_dbg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  sba_dbg_if.master    bus
);

  if (TIMEOUT_CYCLES < 1 ||
      (TIMEOUT_CYCLES - 1) >= (1 << TO_W)) begin : g_bad
    $error("TO_W cannot hold TIMEOUT_CYCLES-1");
  end

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] dat_q, dat_d;
  logic        stb_q, stb_d;
  logic [3:0]  we_q, we_d;
  logic        ovr_q, ovr_d;
  logic        ld;
  logic [31:0] ld_word;
  logic        ld_four;
  logic        ser_last;
  logic        to_hit;

`ifdef SBA_DBG_TIMEOUT_EN
  logic [TO_W-1:0] to_q;

  // Held at zero outside BUS, so it starts from zero on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != BUS) to_q <= '0;
    else                         to_q <= to_q + 1'b1;
  end

  assign to_hit = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    we_d    = we_q;
    ld      = 1'b0;
    ld_word = {24'h0, RSP_NAK};
    ld_four = 1'b0;
    ovr_d   = ovr_q | (bus.i_rx_valid &&
              (state_q == BUS || state_q == RESP));
    unique case (state_q)
      IDLE: if (bus.i_rx_valid) begin
        cnt_d = 2'd0;
        unique case (1'b1)
          (bus.i_rx_dat == CMD_WR): begin
            wr_d    = 1'b1;
            state_d = ADDR;
          end
          (bus.i_rx_dat == CMD_RD): begin
            wr_d    = 1'b0;
            state_d = ADDR;
          end
          default: begin
            ld      = 1'b1;
            state_d = RESP;
          end
        endcase
      end
      ADDR: if (bus.i_rx_valid) begin
        addr_d = {bus.i_rx_dat, addr_q[31:8]};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = wr_q ? DATA : BUS;
          stb_d   = !wr_q;
        end
      end
      DATA: if (bus.i_rx_valid) begin
        dat_d = {bus.i_rx_dat, dat_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = BUS;
          stb_d   = 1'b1;
          we_d    = 4'hF;
        end
      end
      BUS: begin
        if (stb_q && bus.i_ack) begin
          stb_d   = 1'b0;
          we_d    = 4'h0;
          ld      = 1'b1;
          ld_word = wr_q ? {24'h0, RSP_ACK}
                         : bus.i_dat_r;
          ld_four = !wr_q;
          state_d = RESP;
        end else if (to_hit) begin
          stb_d   = 1'b0;
          we_d    = 4'h0;
          ld      = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (ser_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      ovr_q   <= ovr_d;
    end
  end

  sba_dbg_txser u_txser (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (ld),
    .i_word  (ld_word),
    .i_four  (ld_four),
    .i_ready (bus.i_tx_ready),
    .o_dat   (bus.o_tx_dat),
    .o_valid (bus.o_tx_valid),
    .o_last  (ser_last)
  );

  assign bus.o_addr    = addr_q;
  assign bus.o_dat_w   = dat_q;
  assign bus.o_we      = we_q;
  assign bus.o_stb     = stb_q;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_overrun = ovr_q;

endmodule

// File: doc/sba_dbg_bridge.md
Name: sba_dbg_bridge

Overview:
- Serial-to-SBA debug initiator: parses a byte stream (from a UART receiver byte interface) into word read/write commands and drives them onto the SBA bus as a second initiator.
- Returns results as a byte stream toward a UART transmitter.
- Sits beside rv32 behind an external SBA arbiter; used for firmware loading and memory inspection without CPU involvement.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles to wait for i_ack before abandoning a bus access (only with the optional feature).
- TO_W, 10: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_rx_dat  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_dat is valid this cycle. There is no backpressure.
- o_tx_dat  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_dat is valid.
- i_tx_ready  in  1  transmitter accepts the byte when both valid and ready are high.
- o_addr  out  32  SBA address.
- o_dat_w  out  32  SBA write data.
- o_we  out  4  SBA byte write enables.
- o_stb  out  1  SBA strobe.
- i_dat_r  in  32  SBA read data.
- i_ack  in  1  SBA acknowledge.
- o_busy  out  1  high in any state other than IDLE.
- o_overrun  out  1  sticky flag: a byte was dropped.

Behaviour:
- Interface: single clock i_clk; i_rst is synchronous and active-high.
- Reset values: o_stb=0, o_we=0, o_addr=0, o_dat_w=0, o_tx_valid=0, o_tx_dat=0, o_busy=0, o_overrun=0; state IDLE.
- Protocol; multi-byte fields are LSB first:
  - 'W' (0x57) + 4 address bytes + 4 data bytes → word write with o_we=4'hF; reply 0x06.
  - 'R' (0x52) + 4 address bytes → word read; reply 4 data bytes.
  - Any other command byte → reply 0x15 (NAK); no bus access.
- FSM: IDLE → ADDR → (DATA if W) → BUS → RESP → IDLE.
  - A 2-bit byte counter indexes the address and data bytes; it wraps at 3 → next state.
  - Address is assembled in a shift register; the 4th address byte completes the address in the same cycle it is sampled.
- BUS state:
  - o_stb rises on the first cycle of BUS; o_addr, o_dat_w and o_we are stable while o_stb=1.
  - o_stb holds until i_ack is sampled high, then o_stb=0 and o_we=0 on the next cycle.
  - i_dat_r is captured in the cycle i_ack=1.
  - Zero-wait responders ack in the same cycle stb is high; a BUS phase lasts at least 1 cycle.
- RESP state:
  - o_tx_valid=1 with the current byte.
  - On valid&&ready, advance to the next byte, or return to IDLE after the last byte.
  - o_tx_dat never changes while o_tx_valid=1 and i_tx_ready=0.
  - Back-to-back bytes are allowed (1 byte/cycle when ready is held high).
- i_rx_valid in BUS or RESP: byte dropped, o_overrun set; cleared only by reset.
- i_rx_valid in IDLE/ADDR/DATA is always consumed.
- i_ack with o_stb=0 is ignored.
- Reset mid-operation: everything returns to reset values on the next edge, including o_stb dropping mid-access. Partial commands are discarded.
- Latency: a read command's last address byte → o_stb high on the next cycle. Ack cycle → o_tx_valid high on the next cycle.

Optional Feature:
- Macro SBA_DBG_TIMEOUT_EN.
- Defined:
  - The counter resets on entry to BUS.
  - If i_ack has not arrived after TIMEOUT_CYCLES cycles with o_stb high, drop o_stb and reply the single byte 0x15 instead of the normal reply.
  - The 0x15 reply replaces both the read data and the write ACK.
- Not defined: BUS waits indefinitely for i_ack, and no counter logic exists.

Decomposition:
- Package sba_dbg_pkg holds:
  - Command constants CMD_WR=8'h57 and CMD_RD=8'h52.
  - Reply constants RSP_ACK=8'h06 and RSP_NAK=8'h15.
  - The state enum IDLE/ADDR/DATA/BUS/RESP.
- One natural sub-module, sba_dbg_txser: loads a 32-bit word plus a byte count (1 or 4) and serialises it LSB first with the valid/ready handshake.

Test Plan:
1. Send 57 00 01 00 80 EF BE AD DE, responder ack after 2 wait cycles → one access with o_addr=0x80000100, o_dat_w=0xDEADBEEF, o_we=F; o_stb high 3 cycles; tx 0x06.
2. Send 52 00 01 00 80, responder returns 0xDEADBEEF with zero-wait ack → o_stb high 1 cycle; tx EF BE AD DE in order.
3. Read with i_tx_ready toggling 1,0,0,1,… → each byte is held stable until accepted; no byte is lost or duplicated.
4. Send 0x41 → tx 0x15, o_stb never asserted, back to IDLE; a following valid read succeeds.
5. Inject an rx byte during BUS and during RESP → o_overrun=1, transaction result unaffected; i_rst pulse mid-BUS → o_stb=0, o_busy=0, o_overrun=0 the next cycle.
6. With SBA_DBG_TIMEOUT_EN and TIMEOUT_CYCLES=16, read with i_ack tied low → o_stb high exactly 16 cycles, then tx 0x15 and return to IDLE.
